// File: rtl/engine_sample_scheduler.sv
// Sample scheduler between an I2S receive/transmit path and a processing engine.
// Synchronizes rx_valid, launches the engine once per sample, and commits or bypasses on timeout.
module engine_sample_scheduler #(
  parameter int unsigned sample_size    = 16,
  parameter int unsigned timeout_cycles = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_valid,
  input  logic [sample_size-1:0] rx_sample,
  input  logic                   engine_ready,
  input  logic [sample_size-1:0] engine_out,
  input  logic                   clear_status,
  output logic                   tick,
  output logic [sample_size-1:0] engine_in,
  output logic [sample_size-1:0] tx_sample,
  output logic                   busy,
  output logic                   overrun,
  output logic [7:0]             overrun_count,
  output logic                   timeout
);

  localparam int unsigned cnt_w = $clog2(timeout_cycles) + 1;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(timeout_cycles - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0]       state;
  logic             rx_sync1;
  logic             rx_sync2;
  logic             rx_edge;
  logic [cnt_w-1:0] run_cnt;

  logic rx_event;
  logic drop_event;
  logic ready_seen;
  logic run_expired;
  logic timeout_fire;

  // The first RUN cycle has run_cnt == 0; engine_ready is not trusted there.
  always_comb begin
    rx_event     = rx_sync2 & ~rx_edge;
    drop_event   = rx_event & (state != IDLE);
    ready_seen   = engine_ready & (run_cnt != '0);
    run_expired  = (run_cnt == last_cnt) & ~ready_seen;
    timeout_fire = (state == RUN) & run_expired;
    busy         = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rx_sync1  <= 1'b0;
      rx_sync2  <= 1'b0;
      rx_edge   <= 1'b0;
      run_cnt   <= '0;
      tick      <= 1'b0;
      engine_in <= '0;
      tx_sample <= '0;
    end else begin
      rx_sync1 <= rx_valid;
      rx_sync2 <= rx_sync1;
      rx_edge  <= rx_sync2;
      tick     <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_event) begin
            engine_in <= rx_sample;
            tick      <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          run_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          // Leaving at last_cnt keeps the counter from ever wrapping.
          if (ready_seen) begin
            state <= COMMIT;
          end else if (run_expired) begin
            tx_sample <= engine_in;
            state     <= IDLE;
          end else begin
            run_cnt <= run_cnt + cnt_w'(1);
          end
        end
        COMMIT: begin
          tx_sample <= engine_out;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A drop or timeout in the same cycle as clear_status survives the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun       <= 1'b0;
      overrun_count <= '0;
      timeout       <= 1'b0;
    end else begin
      if (drop_event) begin
        overrun <= 1'b1;
      end else if (clear_status) begin
        overrun <= 1'b0;
      end

      if (clear_status) begin
        overrun_count <= drop_event ? 8'd1 : 8'd0;
      end else if (drop_event && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end

      if (timeout_fire) begin
        timeout <= 1'b1;
      end else if (clear_status) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_engine_sample_scheduler.sv
// Bench for engine_sample_scheduler: directed flows plus randomized transactions
// checked against a transaction-level model of the scheduling rules.
module tb_engine_sample_scheduler;

  localparam int unsigned TO_A = 16;
  localparam int unsigned TO_B = 100000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [15:0] rx_sample;
  logic        engine_ready;
  logic [15:0] engine_out;
  logic        clear_status;

  logic        a_tick, a_busy, a_overrun, a_timeout;
  logic [15:0] a_engine_in, a_tx_sample;
  logic [7:0]  a_overrun_count;
  logic        b_tick, b_busy, b_overrun, b_timeout;
  logic [15:0] b_engine_in, b_tx_sample;
  logic [7:0]  b_overrun_count;

  always #5 clk = ~clk;

  engine_sample_scheduler #(.sample_size(16), .timeout_cycles(TO_A)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_sample(rx_sample),
    .engine_ready(engine_ready), .engine_out(engine_out), .clear_status(clear_status),
    .tick(a_tick), .engine_in(a_engine_in), .tx_sample(a_tx_sample), .busy(a_busy),
    .overrun(a_overrun), .overrun_count(a_overrun_count), .timeout(a_timeout)
  );

  engine_sample_scheduler #(.sample_size(16), .timeout_cycles(TO_B)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_sample(rx_sample),
    .engine_ready(engine_ready), .engine_out(engine_out), .clear_status(clear_status),
    .tick(b_tick), .engine_in(b_engine_in), .tx_sample(b_tx_sample), .busy(b_busy),
    .overrun(b_overrun), .overrun_count(b_overrun_count), .timeout(b_timeout)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned a_ticks = 0;
  int unsigned exp_ticks = 0;
  bit          exp_ovr;
  bit          exp_to;
  int unsigned exp_cnt;

  always @(negedge clk) if (a_tick === 1'b1) a_ticks++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    exp_ovr = 1'b0;
    exp_to  = 1'b0;
    exp_cnt = 0;
  endfunction

  function automatic void model_drop();
    exp_ovr = 1'b1;
    if (exp_cnt < 255) exp_cnt++;
  endfunction

  task automatic check_flags_a();
    check_val("a_overrun", 32'(a_overrun), 32'(exp_ovr));
    check_val("a_overrun_count", 32'(a_overrun_count), exp_cnt);
    check_val("a_timeout", 32'(a_timeout), 32'(exp_to));
  endtask

  task automatic check_zero_a();
    check_val("rst_tick", 32'(a_tick), 32'd0);
    check_val("rst_busy", 32'(a_busy), 32'd0);
    check_val("rst_engine_in", 32'(a_engine_in), 32'd0);
    check_val("rst_tx_sample", 32'(a_tx_sample), 32'd0);
    check_flags_a();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; rx_valid = 1'b0; clear_status = 1'b0; engine_ready = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  // Raises rx_valid for one sample and checks tick lands in the cycle after E+2.
  task automatic launch_txn(input logic [15:0] s);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_sample = s; engine_ready = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check_val("tick_e0", 32'(a_tick), 32'd0);
    @(negedge clk);
    check_val("tick_e1", 32'(a_tick), 32'd0);
    @(negedge clk);
    check_val("tick_e2", 32'(a_tick), 32'd1);
    check_val("launch_engine_in", 32'(a_engine_in), 32'(s));
    check_val("launch_busy", 32'(a_busy), 32'd1);
    exp_ticks++;
  endtask

  // Acts as the engine: result appears at RUN cycle 'lat'; before that engine_out is junk.
  task automatic finish_txn(input logic [15:0] s, input int unsigned lat, input logic [15:0] eo,
                            input bit extra, input bit stay);
    bit done = 1'b0;
    logic [15:0] exp_tx;
    @(posedge clk); #1;
    rx_valid = 1'b0; engine_out = ~eo; engine_ready = stay;
    for (int unsigned j = 1; j < 40; j++) begin
      @(posedge clk); #1;
      if (j == 1) engine_ready = 1'b0;
      if (j == lat) begin engine_ready = 1'b1; engine_out = eo; end
      if (extra && j == 1) begin rx_valid = 1'b1; rx_sample = 16'($urandom); end
      if (extra && j == 2) rx_valid = 1'b0;
      @(negedge clk);
      if (a_busy === 1'b0) begin done = 1'b1; break; end
    end
    check_val("txn_completes", 32'(done), 32'd1);
    rx_valid = 1'b0;
    engine_ready = 1'b1;
    if (lat <= TO_A - 1) exp_tx = eo;
    else begin exp_tx = s; exp_to = 1'b1; end
    if (extra) model_drop();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("tx_sample", 32'(a_tx_sample), 32'(exp_tx));
    check_val("engine_in_kept", 32'(a_engine_in), 32'(s));
    check_val("idle_busy", 32'(a_busy), 32'd0);
    check_val("tick_count", a_ticks, exp_ticks);
    check_flags_a();
  endtask

  task automatic pulse_rx(input bit clr);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_sample = 16'($urandom);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    clear_status = clr;
    @(posedge clk); #1;
    clear_status = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] s, eo, b_first;
    int unsigned lat;
    bit extra, stay;

    reset_n = 1'b0; rx_valid = 1'b0; rx_sample = '0; engine_ready = 1'b1;
    engine_out = '0; clear_status = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_zero_a();
    check_val("b_rst_busy", 32'(b_busy), 32'd0);

    // Nominal flow
    launch_txn(16'h1234);
    finish_txn(16'h1234, 5, 16'hABCD, 1'b0, 1'b0);

    // Timeout exactly 16 RUN cycles after LAUNCH
    launch_txn(16'h0F0F);
    @(posedge clk); #1 engine_ready = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check_val("to_not_yet", 32'(a_timeout), 32'd0);
    check_val("to_busy_yet", 32'(a_busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    exp_to = 1'b1;
    check_val("to_flag", 32'(a_timeout), 32'd1);
    check_val("to_bypass", 32'(a_tx_sample), 32'h0F0F);
    check_val("to_idle", 32'(a_busy), 32'd0);
    engine_ready = 1'b1;

    @(posedge clk); #1 clear_status = 1'b1;
    @(posedge clk); #1 clear_status = 1'b0;
    model_clear();
    @(negedge clk);
    check_flags_a();

    // Timeout coincident with clear_status
    launch_txn(16'h3C3C);
    @(posedge clk); #1 engine_ready = 1'b0;
    repeat (15) @(posedge clk);
    #1 clear_status = 1'b1;
    @(posedge clk); #1 clear_status = 1'b0;
    @(negedge clk);
    exp_to = 1'b1;
    check_val("to_vs_clear", 32'(a_timeout), 32'd1);
    check_val("to_vs_clear_tx", 32'(a_tx_sample), 32'h3C3C);
    engine_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      s   = 16'($urandom);
      eo  = 16'($urandom);
      lat = (i == 0) ? 15 : (i == 1) ? 16 : $urandom_range(1, 20);
      extra = (lat >= 2) && ($urandom_range(0, 1) == 1);
      stay  = ($urandom_range(0, 1) == 1);
      launch_txn(s);
      finish_txn(s, lat, eo, extra, stay);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1 clear_status = 1'b1;
        @(posedge clk); #1 clear_status = 1'b0;
        model_clear();
        @(negedge clk);
        check_flags_a();
      end
    end

    // Reset mid-RUN with rx_valid high across the reset release
    launch_txn(16'h2222);
    @(posedge clk); #1 engine_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0; rx_valid = 1'b1; rx_sample = 16'h5A5A; engine_ready = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    model_clear();
    @(negedge clk);
    check_zero_a();
    @(negedge clk);
    check_val("rel_tick0", 32'(a_tick), 32'd0);
    @(negedge clk);
    check_val("rel_tick1", 32'(a_tick), 32'd0);
    @(negedge clk);
    check_val("rel_tick2", 32'(a_tick), 32'd1);
    check_val("rel_engine_in", 32'(a_engine_in), 32'h5A5A);
    exp_ticks++;
    finish_txn(16'h5A5A, 3, 16'h7777, 1'b0, 1'b0);

    // Overrun saturation and clear precedence on the long-timeout instance
    do_reset();
    engine_ready = 1'b0;
    pulse_rx(1'b0);
    b_first = b_engine_in;
    check_val("b_run_busy", 32'(b_busy), 32'd1);
    check_val("b_no_ovr", 32'(b_overrun), 32'd0);
    for (int unsigned k = 1; k <= 300; k++) begin
      pulse_rx(1'b0);
      if (k == 1) check_val("b_ovr_first", 32'(b_overrun), 32'd1);
      if (k == 1 || k == 7 || k == 254 || k == 255 || k == 256 || k == 300)
        check_val("b_ovr_count", 32'(b_overrun_count), (k < 255) ? k : 32'd255);
    end
    check_val("b_engine_in_kept", 32'(b_engine_in), 32'(b_first));
    check_val("b_still_busy", 32'(b_busy), 32'd1);
    check_val("b_no_timeout", 32'(b_timeout), 32'd0);

    @(posedge clk); #1 clear_status = 1'b1;
    @(posedge clk); #1 clear_status = 1'b0;
    @(negedge clk);
    check_val("b_clr_ovr", 32'(b_overrun), 32'd0);
    check_val("b_clr_count", 32'(b_overrun_count), 32'd0);
    repeat (7) pulse_rx(1'b0);
    check_val("b_count7", 32'(b_overrun_count), 32'd7);
    pulse_rx(1'b1);
    check_val("b_clr_vs_ovr", 32'(b_overrun), 32'd1);
    check_val("b_clr_vs_count", 32'(b_overrun_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/engine_sample_scheduler.md
ENGINE_SAMPLE_SCHEDULER -- requirements
Module: engine_sample_scheduler

Interface
REQ-001 Parameter sample_size, default 16: width of the sample and engine data paths.
REQ-002 Parameter timeout_cycles, default 4096: maximum clk cycles the engine may run per sample.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 rx_valid  input  1  I2S receive-valid level, asynchronous to clk.
REQ-006 rx_sample  input  sample_size  received sample, stable while rx_valid is high.
REQ-007 engine_ready  input  1  engine idle/done; drops within 1 clk of tick.
REQ-008 engine_out  input  sample_size  engine result sample.
REQ-009 clear_status  input  1  single-cycle pulse that clears the status outputs.
REQ-010 tick  output  1  single-cycle engine start pulse.
REQ-011 engine_in  output  sample_size  registered sample presented to the engine.
REQ-012 tx_sample  output  sample_size  registered sample for I2S transmit.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 overrun  output  1  sticky flag: a sample arrived while busy.
REQ-015 overrun_count  output  8  saturating count of dropped samples.
REQ-016 timeout  output  1  sticky flag: the engine exceeded timeout_cycles.

Function
REQ-017 rx_valid SHALL pass through a 2-flop synchronizer plus an edge register; an event is sync2 high with the edge register low.
REQ-018 The FSM states SHALL be IDLE, LAUNCH, RUN and COMMIT.
REQ-019 IDLE + event: capture rx_sample into engine_in, go to LAUNCH; with rx_valid first sampled high at edge E, tick is high for exactly the cycle following edge E+2.
REQ-020 LAUNCH: tick=1 for one cycle, clear the run counter, go to RUN.
REQ-021 RUN: the run counter increments each cycle; engine_ready is ignored in the first RUN cycle.
REQ-022 RUN: from the second RUN cycle, engine_ready=1 SHALL move the FSM to COMMIT.
REQ-023 COMMIT: tx_sample <= engine_out, go to IDLE; the total is one tick and one tx_sample update per accepted sample.
REQ-024 RUN: counter == timeout_cycles-1 with engine_ready=0 SHALL set timeout=1, load tx_sample <= engine_in (dry bypass) and go to IDLE.
REQ-025 If engine_ready and the timeout condition occur in the same cycle, COMMIT wins and timeout is not set.
REQ-026 An event in any state other than IDLE is dropped: set overrun=1 and increment overrun_count, saturating at 255.
REQ-027 Dropped events SHALL NOT alter engine_in, tick or the state.
REQ-028 clear_status zeroes overrun, overrun_count and timeout.
REQ-029 clear_status coincident with an overrun event SHALL give overrun=1 and overrun_count=1.
REQ-030 clear_status coincident with a timeout SHALL give timeout=1.
REQ-031 rx_valid held high for many cycles SHALL produce only one event; a new event requires a low level to propagate through the synchronizer first.
REQ-032 The run counter SHALL be at least clog2(timeout_cycles)+1 bits wide and SHALL NOT wrap before the timeout check.

Reset
REQ-033 reset_n=0 at a clk edge SHALL force IDLE and zero tick, busy, engine_in, tx_sample, overrun, overrun_count, timeout, the synchronizer, the edge register and the run counter.
REQ-034 A reset in LAUNCH/RUN/COMMIT aborts the operation with no COMMIT and no tx_sample update; an rx_valid already high at reset release yields one event after 2 synchronizer cycles.

Verification
REQ-035 Nominal flow:
- Stimulus: rx_valid rises with rx_sample=0x1234; engine_ready drops 1 cycle after tick and rises 5 cycles later with engine_out=0xABCD.
- Response: tick at E+2, engine_in=0x1234, tx_sample=0xABCD, busy low afterwards, flags 0.
REQ-036 Overrun saturation:
- Stimulus: a second rx_valid pulse arrives during RUN; then 300 pulses arrive with engine_ready held 0 and timeout_cycles=100000.
- Response: overrun=1 with count 1 after the first drop; overrun_count reaches and holds 255.
REQ-037 Timeout:
- Stimulus: timeout_cycles=16, engine_ready stays 0 after tick, rx_sample=0x0F0F.
- Response: timeout=1 exactly 16 RUN cycles after LAUNCH, tx_sample=0x0F0F, state IDLE.
REQ-038 Clear precedence:
- Stimulus: clear_status pulses in the same cycle as an overrun event, with prior count 7.
- Response: overrun=1, overrun_count=1.
REQ-039 Reset mid-operation:
- Stimulus: reset_n=0 for 1 cycle during RUN.
- Response: all outputs 0, tx_sample unchanged from reset value 0, and the next rx_valid rise processes normally.
